// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//   Buffers one tile of DEPTH vectors of WIDTH lanes, then emits it diagonally
//   skewed (lane j delayed j beats) so wavefronts enter the systolic array
//   aligned. LOAD and FEED phases alternate and never overlap.
//   Optional build macro: FEEDER_STALL_EN adds the out_ready back-pressure port.
module systolic_skew_feeder #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_first,
   output logic             out_last
`ifdef FEEDER_STALL_EN
   ,
   input  logic             out_ready
`endif
);

   localparam int BEATS = DEPTH + WIDTH - 1;
   localparam int LCW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [LCW-1:0] LOAD_LAST = LCW'(DEPTH - 1);
   localparam logic [BCW-1:0] BEAT_LAST = BCW'(BEATS - 1);

   localparam logic [0:0] S_LOAD = 1'b0;
   localparam logic [0:0] S_FEED = 1'b1;

   logic [0:0]       r_state;
   logic [LCW-1:0]   r_load_cnt;
   logic [BCW-1:0]   r_beat_cnt;
   logic [WIDTH-1:0] r_buf [DEPTH];

   logic             w_load_hs;
   logic             w_load_done;
   logic             w_consume;
   logic             w_feed_done;
   logic [BCW-1:0]   w_beat_t;
   logic [WIDTH-1:0] w_buf_eff [DEPTH];
   logic [WIDTH-1:0] w_beat;

   assign in_ready    = (r_state == S_LOAD);
   assign w_load_hs   = in_valid && in_ready;
   assign w_load_done = w_load_hs && (r_load_cnt == LOAD_LAST);

`ifdef FEEDER_STALL_EN
   assign w_consume   = (r_state == S_FEED) && out_valid && out_ready;
`else
   assign w_consume   = (r_state == S_FEED);
`endif

   assign w_feed_done = w_consume && (r_beat_cnt == BEAT_LAST);

   // Index of the beat that will be visible after the next edge: beat 0 when
   // the tile completes, otherwise the successor of the current beat.
   assign w_beat_t    = (r_state == S_FEED) ? r_beat_cnt + 1'b1 : '0;

   // Tile view including the vector being written this cycle, so beat 0 can be
   // registered on the same edge as the final load.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      for (int k = 0; k < DEPTH; k++) begin
         w_buf_eff[k] = r_buf[k];
      end
      if (w_load_hs) begin
         w_buf_eff[r_load_cnt] = in_data;
      end
   end

   // Skewed beat t: lane j carries vector (t-j) when that vector exists, else 0.
   always_comb begin
      w_beat = '0;
      for (int j = 0; j < WIDTH; j++) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (w_beat_t == BCW'(k + j)) begin
               w_beat[j] = w_buf_eff[k][j];
            end
         end
      end
   end

   // Tile buffer write on each load handshake.
   always_ff @(posedge clk) begin
      // NOTE: the buffer has no reset; its contents are only read after a full tile is loaded.
      if (rst_n && w_load_hs) begin
         r_buf[r_load_cnt] <= in_data;
      end
   end

   // Phase control, counters and registered output beat.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         r_state    <= S_LOAD;
         r_load_cnt <= '0;
         r_beat_cnt <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_first  <= 1'b0;
         out_last   <= 1'b0;
      end else if (r_state == S_LOAD) begin
         if (w_load_done) begin
            r_state    <= S_FEED;
            r_load_cnt <= '0;
            r_beat_cnt <= w_beat_t;
            out_valid  <= 1'b1;
            out_data   <= w_beat;
            out_first  <= 1'b1;
            out_last   <= (w_beat_t == BEAT_LAST);
         end else if (w_load_hs) begin
            r_load_cnt <= r_load_cnt + 1'b1;
         end
      end else begin
         if (w_feed_done) begin
            r_state    <= S_LOAD;
            r_beat_cnt <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
         end else if (w_consume) begin
            r_beat_cnt <= w_beat_t;
            out_data   <= w_beat;
            out_first  <= 1'b0;
            out_last   <= (w_beat_t == BEAT_LAST);
         end
      end
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder
//   Directed scenarios plus randomized traffic against a queue-based model of
//   the skewed tile feeder. FEEDER_STALL_EN selects the back-pressure build.
module tb_systolic_skew_feeder;

   localparam int W     = 8;
   localparam int D     = 8;
   localparam int BEATS = D + W - 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_first;
   logic         out_last;
   logic         out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   systolic_skew_feeder #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_first (out_first),
      .out_last  (out_last)
`ifdef FEEDER_STALL_EN
      ,
      .out_ready (out_ready)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0] m_tile[$];
   bit           m_feed = 1'b0;
   int           m_beat = 0;
   bit           checking = 1'b0;

   function automatic logic [W-1:0] model_beat(input int t);
      logic [W-1:0] r;
      r = '0;
      for (int j = 0; j < W; j++) begin
         if (t - j >= 0 && t - j < D) r[j] = m_tile[t - j][j];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      bit cons;
`ifdef FEEDER_STALL_EN
      cons = out_ready;
`else
      cons = 1'b1;
`endif
      if (!rst_n) begin
         m_feed = 1'b0;
         m_beat = 0;
         m_tile.delete();
      end else if (!m_feed) begin
         if (in_valid) begin
            m_tile.push_back(in_data);
            if (m_tile.size() == D) begin
               m_feed = 1'b1;
               m_beat = 0;
            end
         end
      end else if (cons) begin
         if (m_beat == BEATS - 1) begin
            m_feed = 1'b0;
            m_tile.delete();
         end else begin
            m_beat++;
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         check("in_ready",  in_ready,  !m_feed);
         check("out_valid", out_valid, m_feed);
         check("out_data",  out_data,  m_feed ? model_beat(m_beat) : '0);
         check("out_first", out_first, m_feed && m_beat == 0);
         check("out_last",  out_last,  m_feed && m_beat == BEATS - 1);
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [W-1:0] tile_v [D];
   logic [W-1:0] cap_d[$];
   logic         cap_f[$];
   logic         cap_l[$];
   logic [W-1:0] exp_q[$];
   int           hs;

   task automatic load_tile(input bit gapped);
      int waited = 0;
      hs = 0;
      while (!in_ready && waited < 100) begin
         tick();
         waited++;
      end
      check("load_wait_timeout", in_ready, 1'b1);
      for (int k = 0; k < D; k++) begin
         if (gapped) begin
            in_valid = 1'b0;
            tick();
         end
         in_valid = 1'b1;
         in_data  = tile_v[k];
         if (in_ready) hs++;
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic capture(input bit hold_valid, input int stall_at, input int stall_len);
      cap_d.delete();
      cap_f.delete();
      cap_l.delete();
      for (int c = 0; c < 60; c++) begin
         if (!out_valid) break;
         cap_d.push_back(out_data);
         cap_f.push_back(out_first);
         cap_l.push_back(out_last);
         out_ready = !(c >= stall_at && c < stall_at + stall_len);
         if (hold_valid) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("feed_timeout", out_valid, 1'b0);
      check("ready_after_feed", in_ready, 1'b1);
   endtask

   task automatic compare_seq(input string name);
      check({name, "_len"}, cap_d.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap_d.size(); i++) begin
         check(name, cap_d[i], exp_q[i]);
      end
   endtask

   task automatic set_all_ones_exp();
      logic [W-1:0] lit [BEATS];
      lit = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
              8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
      exp_q.delete();
      for (int i = 0; i < BEATS; i++) exp_q.push_back(lit[i]);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hA5;
      out_ready = 1'b1;

      // 1: reset held two cycles with in_valid asserted
      tick();
      checking = 1'b1;
      tick();
      check("rst_in_ready",  in_ready,  1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data",  out_data,  8'h00);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      tick();

      // 2: all-ones tile back-to-back, input held high through FEED
      for (int k = 0; k < D; k++) tile_v[k] = 8'hFF;
      load_tile(1'b0);
      capture(1'b1, 1000, 0);
      set_all_ones_exp();
      compare_seq("all_ones");
      if (cap_f.size() == BEATS) begin
         check("first_beat0",  cap_f[0], 1'b1);
         check("first_beat1",  cap_f[1], 1'b0);
         check("last_beat13",  cap_l[BEATS-2], 1'b0);
         check("last_beat14",  cap_l[BEATS-1], 1'b1);
      end
      tick();

      // 3: diagonal tile
      for (int k = 0; k < D; k++) tile_v[k] = W'(1 << k);
      load_tile(1'b0);
      capture(1'b0, 1000, 0);
      exp_q.delete();
      for (int t = 0; t < BEATS; t++) exp_q.push_back((t % 2 == 0) ? W'(1 << (t / 2)) : 8'h00);
      compare_seq("diagonal");

      // 4: gapped load of all-ones
      for (int k = 0; k < D; k++) tile_v[k] = 8'hFF;
      load_tile(1'b1);
      check("gapped_handshakes", hs, 8);
      capture(1'b0, 1000, 0);
      set_all_ones_exp();
      compare_seq("gapped");

      // 5: reset in the middle of FEED, then a fresh tile
      load_tile(1'b0);
      repeat (5) tick();
      check("beat5_data", out_data, 8'h3F);
      rst_n = 1'b0;
      tick();
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_in_ready",  in_ready,  1'b1);
      rst_n = 1'b1;
      for (int k = 0; k < D; k++) tile_v[k] = W'(1 << k);
      load_tile(1'b0);
      capture(1'b0, 1000, 0);
      exp_q.delete();
      for (int t = 0; t < BEATS; t++) exp_q.push_back((t % 2 == 0) ? W'(1 << (t / 2)) : 8'h00);
      compare_seq("after_midrst");

`ifdef FEEDER_STALL_EN
      // 6: three-cycle stall at beat 7
      for (int k = 0; k < D; k++) tile_v[k] = 8'hFF;
      load_tile(1'b0);
      capture(1'b0, 7, 3);
      set_all_ones_exp();
      exp_q.insert(7, 8'hFF);
      exp_q.insert(7, 8'hFF);
      exp_q.insert(7, 8'hFF);
      compare_seq("stall");
`endif

      // 7: randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         in_data   = W'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         rst_n     = ($urandom_range(0, 299) != 0);
         tick();
      end
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();

      checking = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
